// File: rtl/machine_counters.sv
// machine_counters: mcycle/minstret 64-bit counters with CSR read/write access
// and read-only user shadows at 0xCxx.
`default_nettype none

module machine_counters #(
   parameter logic [63:0] MCYCLE_RESET   = 64'h0,
   parameter logic [63:0] MINSTRET_RESET = 64'h0
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        mcountinhibit_cy_in,
   input  logic        mcountinhibit_ir_in,
   input  logic        instret_inc_in,
   input  logic [11:0] csr_addr_in,
   input  logic        wr_en_in,
   input  logic [31:0] data_wr_in,
   input  logic        rd_en_in,
   output logic [31:0] csr_rd_data_out,
   output logic        rd_valid_out,
   output logic        csr_hit_out,
   output logic [63:0] mcycle_out,
   output logic [63:0] minstret_out
);

   localparam logic [11:0] ADDR_MCYCLE     = 12'hB00;
   localparam logic [11:0] ADDR_MCYCLEH    = 12'hB80;
   localparam logic [11:0] ADDR_MINSTRET   = 12'hB02;
   localparam logic [11:0] ADDR_MINSTRETH  = 12'hB82;
   localparam logic [11:0] ADDR_CYCLE      = 12'hC00;
   localparam logic [11:0] ADDR_CYCLEH     = 12'hC80;
   localparam logic [11:0] ADDR_INSTRET    = 12'hC02;
   localparam logic [11:0] ADDR_INSTRETH   = 12'hC82;

   logic [63:0] mcycle;
   logic [63:0] minstret;
   logic [63:0] mcycle_next;
   logic [63:0] minstret_next;
   logic        cy_inc;
   logic        ir_inc;
   logic [31:0] rd_sel;
   logic        rd_hit;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        hit;

   // A low-half write replaces the low word and suppresses the increment;
   // a high-half write keeps the low increment but drops its carry.
   function automatic logic [63:0] next_count(
      input logic [63:0] cur,
      input logic        inc,
      input logic        wr_lo,
      input logic        wr_hi,
      input logic [31:0] d
   );
      logic [31:0] lo_inc;
      lo_inc = cur[31:0] + {31'b0, inc};
      if (wr_lo)
         next_count = {cur[63:32], d};
      else if (wr_hi)
         next_count = {d, lo_inc};
      else
         next_count = cur + {63'b0, inc};
   endfunction

   always_comb begin
      cy_inc        = ~mcountinhibit_cy_in;
      ir_inc        = instret_inc_in & ~mcountinhibit_ir_in;
      mcycle_next   = next_count(mcycle, cy_inc,
                                 wr_en_in && (csr_addr_in == ADDR_MCYCLE),
                                 wr_en_in && (csr_addr_in == ADDR_MCYCLEH),
                                 data_wr_in);
      minstret_next = next_count(minstret, ir_inc,
                                 wr_en_in && (csr_addr_in == ADDR_MINSTRET),
                                 wr_en_in && (csr_addr_in == ADDR_MINSTRETH),
                                 data_wr_in);
   end

   always_comb begin
      rd_sel = 32'h0;
      rd_hit = 1'b1;
      case (csr_addr_in)
         ADDR_MCYCLE,   ADDR_CYCLE:    rd_sel = mcycle[31:0];
         ADDR_MCYCLEH,  ADDR_CYCLEH:   rd_sel = mcycle[63:32];
         ADDR_MINSTRET, ADDR_INSTRET:  rd_sel = minstret[31:0];
         ADDR_MINSTRETH, ADDR_INSTRETH: rd_sel = minstret[63:32];
         default:                      rd_hit = 1'b0;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         mcycle   <= MCYCLE_RESET;
         minstret <= MINSTRET_RESET;
         rd_data  <= 32'h0;
         rd_valid <= 1'b0;
         hit      <= 1'b0;
      end else begin
         mcycle   <= mcycle_next;
         minstret <= minstret_next;
         rd_valid <= rd_en_in;
         if (rd_en_in) begin
            rd_data <= rd_sel;
            hit     <= rd_hit;
         end
      end
   end

   assign csr_rd_data_out = rd_data;
   assign rd_valid_out    = rd_valid;
   assign csr_hit_out     = hit;
   assign mcycle_out      = mcycle;
   assign minstret_out    = minstret;

endmodule

`default_nettype wire

// File: tb/tb_machine_counters.sv
// Bench for machine_counters: directed vector table plus randomized run
// against a 64-bit arithmetic reference model.
`default_nettype none

module tb_machine_counters;

   logic        clk = 1'b0;
   logic        rst, cy, ir, inc, wr, rd;
   logic [11:0] addr;
   logic [31:0] wdata;
   logic [31:0] rd_data;
   logic        rd_valid, hit;
   logic [63:0] mc, mi;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   machine_counters dut (
      .clk_in              (clk),
      .rst_in              (rst),
      .mcountinhibit_cy_in (cy),
      .mcountinhibit_ir_in (ir),
      .instret_inc_in      (inc),
      .csr_addr_in         (addr),
      .wr_en_in            (wr),
      .data_wr_in          (wdata),
      .rd_en_in            (rd),
      .csr_rd_data_out     (rd_data),
      .rd_valid_out        (rd_valid),
      .csr_hit_out         (hit),
      .mcycle_out          (mc),
      .minstret_out        (mi)
   );

   typedef struct {
      logic        rst, cy, ir, inc, wr, rd;
      logic [11:0] addr;
      logic [31:0] data;
      logic [63:0] e_mc, e_mi;
      logic        e_v, e_hit;
      logic [31:0] e_rd;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic r, input logic c, input logic i, input logic n,
                               input logic w, input logic [11:0] a, input logic [31:0] d,
                               input logic q, input logic [63:0] emc, input logic [63:0] emi,
                               input logic ev, input logic eh, input logic [31:0] erd);
      vec_t v;
      v.rst = r; v.cy = c; v.ir = i; v.inc = n; v.wr = w; v.addr = a; v.data = d;
      v.rd = q; v.e_mc = emc; v.e_mi = emi; v.e_v = ev; v.e_hit = eh; v.e_rd = erd;
      tbl.push_back(v);
   endfunction

   // Drive one cycle, let the edge pass, then compare away from the edge.
   task automatic apply(input vec_t v, input string tag, input int idx);
      rst = v.rst; cy = v.cy; ir = v.ir; inc = v.inc; wr = v.wr;
      addr = v.addr; wdata = v.data; rd = v.rd;
      @(posedge clk);
      #1;
      vectors++;
      if (mc !== v.e_mc) begin
         miscompares++;
         $display("FAIL %s[%0d] mcycle: got %h expected %h", tag, idx, mc, v.e_mc);
      end
      if (mi !== v.e_mi) begin
         miscompares++;
         $display("FAIL %s[%0d] minstret: got %h expected %h", tag, idx, mi, v.e_mi);
      end
      if (rd_valid !== v.e_v) begin
         miscompares++;
         $display("FAIL %s[%0d] rd_valid: got %b expected %b", tag, idx, rd_valid, v.e_v);
      end
      if (v.e_v || v.rst) begin
         if (hit !== v.e_hit) begin
            miscompares++;
            $display("FAIL %s[%0d] csr_hit: got %b expected %b", tag, idx, hit, v.e_hit);
         end
         if (rd_data !== v.e_rd) begin
            miscompares++;
            $display("FAIL %s[%0d] rd_data: got %h expected %h", tag, idx, rd_data, v.e_rd);
         end
      end
   endtask

   // Reference model: plain 64-bit arithmetic on the counter values.
   logic [63:0] m_cy, m_ir;

   function automatic logic [63:0] model_next(input logic [63:0] cur, input logic step,
                                              input logic wlo, input logic whi,
                                              input logic [31:0] d);
      logic [63:0] sum;
      if (wlo) return {cur[63:32], d};
      sum = cur + 64'(step);
      if (whi) return {d, sum[31:0]};
      return sum;
   endfunction

   function automatic logic [32:0] model_read(input logic [11:0] a,
                                              input logic [63:0] c, input logic [63:0] n);
      // bit 32 = hit
      if (a[7:0] == 8'h00 && (a[11:8] == 4'hB || a[11:8] == 4'hC)) return {1'b1, c[31:0]};
      if (a[7:0] == 8'h80 && (a[11:8] == 4'hB || a[11:8] == 4'hC)) return {1'b1, c[63:32]};
      if (a[7:0] == 8'h02 && (a[11:8] == 4'hB || a[11:8] == 4'hC)) return {1'b1, n[31:0]};
      if (a[7:0] == 8'h82 && (a[11:8] == 4'hB || a[11:8] == 4'hC)) return {1'b1, n[63:32]};
      return 33'h0;
   endfunction

   initial begin
      logic [11:0] addrs [0:7];
      rst = 1'b1; cy = 1'b0; ir = 1'b0; inc = 1'b0; wr = 1'b0; rd = 1'b0;
      addr = 12'h0; wdata = 32'h0;

      // rst cy ir inc wr addr data rd | mcycle minstret v hit rdata
      add(1,0,0,0, 0,12'hB00,32'h0,        0, 64'h0, 64'h0, 0,0,32'h0);
      add(1,0,0,0, 0,12'hB00,32'h0,        1, 64'h0, 64'h0, 0,0,32'h0);
      for (int k = 1; k <= 10; k++)
         add(0,0,0,0, 0,12'h0,32'h0, 0, 64'(k), 64'h0, 0,0,32'h0);
      add(0,0,0,0, 1,12'hB00,32'hFFFF_FFFE, 0, 64'h0_FFFF_FFFE, 64'h0, 0,0,32'h0);
      add(0,0,0,0, 0,12'h0,32'h0, 0, 64'h0_FFFF_FFFF, 64'h0, 0,0,32'h0);
      add(0,0,0,0, 0,12'h0,32'h0, 0, 64'h1_0000_0000, 64'h0, 0,0,32'h0);
      add(0,0,0,0, 0,12'h0,32'h0, 0, 64'h1_0000_0001, 64'h0, 0,0,32'h0);
      // CY held, instret pulses 1,1,0,1,1
      add(0,1,0,1, 0,12'h0,32'h0, 0, 64'h1_0000_0001, 64'd1, 0,0,32'h0);
      add(0,1,0,1, 0,12'h0,32'h0, 0, 64'h1_0000_0001, 64'd2, 0,0,32'h0);
      add(0,1,0,0, 0,12'h0,32'h0, 0, 64'h1_0000_0001, 64'd2, 0,0,32'h0);
      add(0,1,0,1, 0,12'h0,32'h0, 0, 64'h1_0000_0001, 64'd3, 0,0,32'h0);
      add(0,1,0,1, 0,12'h0,32'h0, 0, 64'h1_0000_0001, 64'd4, 0,0,32'h0);
      for (int k = 0; k < 3; k++)
         add(0,1,1,1, 0,12'h0,32'h0, 0, 64'h1_0000_0001, 64'd4, 0,0,32'h0);
      add(0,1,0,1, 1,12'hB82,32'h1234, 0, 64'h1_0000_0001, 64'h1234_0000_0005, 0,0,32'h0);
      add(0,1,0,0, 1,12'hC02,32'hDEAD, 0, 64'h1_0000_0001, 64'h1234_0000_0005, 0,0,32'h0);
      // preload mcycle to all ones, with reads along the way
      add(0,1,0,0, 1,12'hB80,32'hFFFF_FFFF, 0, 64'hFFFF_FFFF_0000_0001, 64'h1234_0000_0005, 0,0,32'h0);
      add(0,1,0,0, 0,12'h0,32'h0, 1'b0, 64'hFFFF_FFFF_0000_0001, 64'h1234_0000_0005, 0,0,32'h0);
      tbl[tbl.size()-1].rd = 1'b1; tbl[tbl.size()-1].addr = 12'hC80;
      tbl[tbl.size()-1].e_v = 1'b1; tbl[tbl.size()-1].e_hit = 1'b1;
      tbl[tbl.size()-1].e_rd = 32'hFFFF_FFFF;
      add(0,1,0,0, 1,12'hB00,32'hFFFF_FFFF, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_0000_0005, 1,1,32'h0000_0001);
      add(0,0,0,0, 0,12'h0,32'h0, 0, 64'h0, 64'h1234_0000_0005, 0,0,32'h0);
      add(0,0,0,0, 0,12'h7C0,32'h0, 1, 64'h1, 64'h1234_0000_0005, 1,0,32'h0);
      add(0,0,0,0, 0,12'hC02,32'h0, 1, 64'h2, 64'h1234_0000_0005, 1,1,32'h5);
      add(0,0,0,0, 0,12'hC82,32'h0, 1, 64'h3, 64'h1234_0000_0005, 1,1,32'h1234);
      add(1,0,0,1, 1,12'hB00,32'h55, 1, 64'h0, 64'h0, 0,0,32'h0);
      add(0,0,0,0, 0,12'h0,32'h0, 0, 64'h1, 64'h0, 0,0,32'h0);
      add(0,0,0,0, 1,12'hB00,32'hFFFF_FFFF, 0, 64'h0_FFFF_FFFF, 64'h0, 0,0,32'h0);
      add(0,0,0,0, 1,12'hB80,32'h7, 0, 64'h7_0000_0000, 64'h0, 0,0,32'h0);
      add(0,0,0,0, 1,12'hC00,32'h99, 0, 64'h7_0000_0001, 64'h0, 0,0,32'h0);

      for (int k = 0; k < tbl.size(); k++)
         apply(tbl[k], "dir", k);

      // Randomized run against the reference model.
      addrs[0] = 12'hB00; addrs[1] = 12'hB80; addrs[2] = 12'hB02; addrs[3] = 12'hB82;
      addrs[4] = 12'hC00; addrs[5] = 12'hC80; addrs[6] = 12'hC02; addrs[7] = 12'hC82;
      m_cy = 64'h0; m_ir = 64'h0;
      for (int k = 0; k < 2000; k++) begin
         vec_t v;
         logic [32:0] r;
         v.rst  = (k == 0) || ($urandom_range(0, 63) == 0);
         v.cy   = ($urandom_range(0, 3) == 0);
         v.ir   = ($urandom_range(0, 3) == 0);
         v.inc  = $urandom_range(0, 1);
         v.wr   = ($urandom_range(0, 3) == 0);
         v.rd   = $urandom_range(0, 1);
         v.addr = ($urandom_range(0, 7) == 0) ? 12'($urandom) : addrs[$urandom_range(0, 7)];
         case ($urandom_range(0, 3))
            0:       v.data = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            default: v.data = $urandom;
         endcase
         r = model_read(v.addr, m_cy, m_ir);
         v.e_v   = v.rd && !v.rst;
         v.e_hit = v.rst ? 1'b0 : r[32];
         v.e_rd  = v.rst ? 32'h0 : r[31:0];
         if (v.rst) begin
            m_cy = 64'h0;
            m_ir = 64'h0;
         end else begin
            m_cy = model_next(m_cy, !v.cy, v.wr && v.addr == 12'hB00,
                              v.wr && v.addr == 12'hB80, v.data);
            m_ir = model_next(m_ir, v.inc && !v.ir, v.wr && v.addr == 12'hB02,
                              v.wr && v.addr == 12'hB82, v.data);
         end
         v.e_mc = m_cy;
         v.e_mi = m_ir;
         apply(v, "rnd", k);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/machine_counters.md
# machine_counters

Machine-mode cycle and instructions-retired counters (`mcycle`/`mcycleh`, `minstret`/`minstreth`) with CSR read/write access and user-mode read-only shadows (`cycle`/`cycleh`, `instret`/`instreth`). The block sits in the CSR unit and consumes the `mcountinhibit` CY and IR bits driven by the counter-setup register. When a bit is set, it freezes the corresponding counter. The block also takes a retire strobe from the writeback stage, and returns registered read data to the CSR read path.

## Interface
- `MCYCLE_RESET`, default 64'h0, reset value of the cycle counter
- `MINSTRET_RESET`, default 64'h0, reset value of the instret counter
- `clk_in`  input  1  single clock; all state updates on rising edge
- `rst_in`  input  1  synchronous, active-high reset
- `mcountinhibit_cy_in`  input  1  1 = hold `mcycle`
- `mcountinhibit_ir_in`  input  1  1 = hold `minstret`
- `instret_inc_in`  input  1  one instruction retired this cycle
- `csr_addr_in`  input  12  CSR address for both read and write
- `wr_en_in`  input  1  CSR write strobe
- `data_wr_in`  input  32  CSR write data
- `rd_en_in`  input  1  CSR read request
- `csr_rd_data_out`  output  32  registered read data
- `rd_valid_out`  output  1  read data valid; asserted one cycle after `rd_en_in`
- `csr_hit_out`  output  1  registered; 1 = last read address was decoded by this block
- `mcycle_out`  output  64  live cycle counter
- `minstret_out`  output  64  live instret counter

## Operation
- Decoded addresses:
  - 0xB00 and 0xC00 → `mcycle[31:0]`
  - 0xB80 and 0xC80 → `mcycle[63:32]`
  - 0xB02 and 0xC02 → `minstret[31:0]`
  - 0xB82 and 0xC82 → `minstret[63:32]`
- Only the 0xBxx addresses are writable. A write to 0xCxx is ignored and changes no state.
- `mcycle` increments by 1 every cycle when `mcountinhibit_cy_in`=0.
- `minstret` increments by 1 in any cycle where `instret_inc_in`=1 and `mcountinhibit_ir_in`=0.
- Arithmetic is full 64-bit with carry from the low half into the high half. 64'hFFFF_FFFF_FFFF_FFFF wraps to 0. No overflow flag.
- A write to a low half (0xB00/0xB02) in the same cycle as an increment:
  - Low half takes `data_wr_in`; the increment is dropped.
  - High half is unchanged; no carry is generated that cycle.
- A write to a high half (0xB80/0xB82) in the same cycle as an increment:
  - High half takes `data_wr_in`.
  - Low half still increments if enabled; any carry out of the low half is discarded.
- A write to one counter never affects the other counter.
- Reads:
  - When `rd_en_in`=1, the selected 32-bit half is sampled from the pre-update (current) register value.
  - It appears on `csr_rd_data_out` the next cycle, with `rd_valid_out`=1 and `csr_hit_out`=1.
  - An undecoded address gives `csr_rd_data_out`=0, `rd_valid_out`=1, `csr_hit_out`=0.
- Read and write to the same address in the same cycle: the read returns the old value.
- Inhibit bits are sampled in the same cycle they gate; there is no extra pipeline delay.

## Timing
- Reset (`rst_in`=1 at a clock edge):
  - `mcycle` ← MCYCLE_RESET and `minstret` ← MINSTRET_RESET.
  - `csr_rd_data_out`=0, `rd_valid_out`=0, `csr_hit_out`=0.
  - Reset overrides writes, increments and reads in that cycle.
- Reset mid-operation: a read issued in the cycle reset is asserted produces no `rd_valid_out`.
- First increment after reset: `mcycle_out` reads 1 one edge after `rst_in` deasserts, given CY=0.
- Write latency: value is visible on `mcycle_out`/`minstret_out` one edge after `wr_en_in`. It increments from the following edge on.
- Read latency: exactly 1 cycle. `rd_valid_out` is a single-cycle pulse per request, and back-to-back requests are supported every cycle.

## Test plan
- Reset, then 10 cycles with CY=0, IR=0, `instret_inc_in`=0 → `mcycle_out`=10, `minstret_out`=0; all read outputs 0 during reset.
- Write 0xB00 = 32'hFFFF_FFFE, then run 3 cycles → `mcycle_out` reads 0x0_FFFFFFFF, then 0x1_00000000, then 0x1_00000001 (carry into the high half).
- Hold CY=1 for 5 cycles while pulsing `instret_inc_in` 4 times with IR=0 → `mcycle` unchanged, `minstret` +4. Then set IR=1 with 3 more pulses → `minstret` unchanged.
- Write 0xB82 = 32'h1234 together with `instret_inc_in`=1 → `minstret` becomes {0x1234, old_low+1}. A write to 0xC02 leaves `minstret` unchanged.
- Preload `mcycle`=64'hFFFF_FFFF_FFFF_FFFF via two writes → wraps to 0 on the next enabled cycle.
- Read 0xC80 with `rd_en_in` → next cycle `rd_valid_out`=1, `csr_hit_out`=1, data = `mcycle[63:32]`. Read 0x7C0 → `csr_hit_out`=0, data 0. Assert `rst_in` during a read → no valid pulse, counters at reset values.
